// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated TX FIFO, all in sys_clk domain.
// Bit timing comes from an internal divider; frames are sent back-to-back while the FIFO is non-empty.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;
  logic                 r_ready;

  state_t               r_state;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_baud_end;
  logic [LW-1:0]        w_level_nxt;

  state_t               w_state_nxt;
  logic [BW-1:0]        w_baud_nxt;
  logic [3:0]           w_bit_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_tx_nxt;
  logic                 w_done_nxt;

  assign w_push     = tx_valid && r_ready;
  assign w_head     = r_mem[r_rptr];
  assign w_baud_end = (r_baud == BAUD_LAST);

  assign tx_ready   = r_ready;
  assign fifo_level = r_level;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign uart_tx    = r_tx;

  // ---------------- FIFO ----------------
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != FULL);
    end
  end

  // ---------------- Transmit FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bitcnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_tx_nxt   = 1'b1;
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
          w_shift_nxt = w_head;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bitcnt == DATA_LAST) begin
            w_bit_nxt = '0;
            if (PARITY != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt   = r_bitcnt + 1'b1;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = r_shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bitcnt == STOP_LAST) begin
            w_bit_nxt = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (r_level != '0) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
              w_tx_nxt    = 1'b0;
              w_shift_nxt = w_head;
            end else begin
              w_state_nxt = S_IDLE;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Registered pulse: raised on the edge that enters the last stop-bit cycle.
    w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST) &&
                 (w_bit_nxt == STOP_LAST);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bitcnt <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
      if (w_pop) r_par <= (^w_head) ^ ODD_PAR;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated TX FIFO. It runs entirely in the sys_clk domain and generates its own bit timing from a divider, so no separate sample clock is needed. Data bits, parity and stop bits are configurable. It accepts bytes on a valid/ready handshake from the CPU bus-side peripheral logic, queues them, and sends frames back-to-back on uart_tx.

Parameters:
CLK_DIV, 5208, sys_clk cycles per UART bit; legal range 2..65535 (5208 gives 9600 baud at 50 MHz).
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.

Ports:
sys_clk  in  1  system clock; all logic is rising-edge.
reset  in  1  asynchronous, active-low reset.
tx_data  in  DATA_BITS  word to transmit; sent LSB first.
tx_valid  in  1  write request; a word is accepted on an edge where tx_valid && tx_ready.
tx_ready  out  1  FIFO not full.
fifo_level  out  clog2(FIFO_DEPTH)+1  current number of FIFO entries.
tx_busy  out  1  high while a frame is on the line (state != IDLE).
tx_done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.
uart_tx  out  1  serial line; idles high.

Behaviour:
- Reset (async, while reset=0): uart_tx=1, tx_busy=0, tx_done=0, fifo_level=0, tx_ready=1. FSM goes to IDLE, baud and bit counters clear, FIFO pointers clear. Reset mid-frame aborts the frame and drops all queued words.
- FIFO push: on an edge with tx_valid && tx_ready. While full (tx_ready=0), tx_valid is ignored and tx_data is not stored.
- FIFO pop: on the edge where the FSM starts a frame.
- Simultaneous push and pop: fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_level and tx_ready are registered. tx_ready reflects the level after the current edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: uart_tx=1. If fifo_level != 0, then on that edge: pop the head into the shift register, set uart_tx=0, go to START, and clear the baud counter.
  - Each bit is held for exactly CLK_DIV cycles. The baud counter runs 0..CLK_DIV-1, and the state/bit advances on the edge where it equals CLK_DIV-1.
  - START -> DATA: uart_tx=shift[0]. The shift register shifts right once per data bit; the bit counter runs 0..DATA_BITS-1.
  - DATA -> PARITY when PARITY != 0, otherwise DATA -> STOP.
  - Parity bit: XOR of all data bits for even mode; its inverse for odd mode. The total number of ones in data+parity is even or odd respectively. Parity is computed from the popped word, not the shifted remainder.
  - STOP: uart_tx=1 for STOP_BITS*CLK_DIV cycles. On the final cycle, tx_done=1. On the following edge, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: a word accepted at edge N into an empty FIFO with the FSM idle drives uart_tx low after edge N+1.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- Unused upper tx_data bits do not exist; the width is exactly DATA_BITS.
- Outputs uart_tx, tx_busy and tx_done are driven from registers (glitch-free).

Test Plan:
1. CLK_DIV=4, 8N1, idle. Write 0xA5 at edge 0 -> uart_tx goes low after edge 1. The line then carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). tx_done is high on cycle 40 of the frame; tx_busy returns to 0 after it.
2. CLK_DIV=4, PARITY=2, write 0x07 -> parity bit 1. With PARITY=1, the same word gives parity bit 0. STOP_BITS=2 gives 8 high cycles after parity, and frame length is 48 cycles.
3. FIFO_DEPTH=4, idle, tx_valid held high for 6 consecutive edges with data 1..6:
   - words 1..5 are accepted (word 1 is popped at edge 1);
   - tx_ready=0 after edge 4, so word 6 is refused;
   - fifo_level sequence is 1,1,2,3,4,4;
   - frames 1..5 are sent back-to-back with zero idle cycles between stop and start.
4. Simultaneous push and pop: FIFO holds 2 words, a frame ends, and tx_valid=1 on the pop edge -> fifo_level stays 2, and the order of transmitted words is preserved.
5. Assert reset during bit 3 of a frame with 2 words queued -> uart_tx=1 immediately, without waiting for a clock edge. After release, fifo_level=0, tx_busy=0, and no further frames are sent.
6. DATA_BITS=5, CLK_DIV=2, write 0x1F -> line carries 0,1,1,1,1,1,1, each bit held 2 cycles, and tx_done fires on cycle 14.
